// File: rtl/dds_mod_controller.sv
// dds_mod_controller: symbol sequencer for the DDS sine datapath.
// Accepts one data bit per symbol over a valid/ready handshake, holds it
// for SYMBOL_CYCLES clocks and drives phase step, phase offset and amplitude
// gate for ASK (mode 00/11), FSK (01) or BPSK (10).
// Optional preamble: define DDS_CTRL_PREAMBLE_EN to prefix every burst with
// PREAMBLE_LEN alternating 1,0,... symbols before the first data symbol.
module dds_mod_controller #(
  parameter int unsigned PHASE_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned SYMBOL_CYCLES = 64,
  parameter int unsigned INC_F0        = 1,
  parameter int unsigned INC_F1        = 2,
  parameter int unsigned PREAMBLE_LEN  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  output logic                   dds_en,
  output logic                   dds_clr,
  output logic [PHASE_WIDTH-1:0] phase_inc,
  output logic [PHASE_WIDTH-1:0] phase_off,
  output logic                   amp_en,
  output logic                   sym_start,
  output logic                   busy
);

`ifdef DDS_CTRL_PREAMBLE_EN
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_SYM} state_t;
  localparam int unsigned PRE_IW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PRE_IW-1:0] PRE_LAST = PRE_IW'(PREAMBLE_LEN - 1);
`else
  typedef enum logic [1:0] {S_IDLE, S_SYM} state_t;
`endif

  localparam logic [CNT_WIDTH-1:0]   CNT_LAST = CNT_WIDTH'(SYMBOL_CYCLES - 1);
  localparam logic [PHASE_WIDTH-1:0] P_F0     = PHASE_WIDTH'(INC_F0);
  localparam logic [PHASE_WIDTH-1:0] P_F1     = PHASE_WIDTH'(INC_F1);
  localparam logic [PHASE_WIDTH-1:0] P_HALF   = {1'b1, {(PHASE_WIDTH-1){1'b0}}};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [1:0]           r_mode;
  logic                 r_bit;
  logic                 r_clr;
  logic                 w_last;
  logic                 w_xfer;
  logic                 w_active;

`ifdef DDS_CTRL_PREAMBLE_EN
  logic                 r_held;
  logic [PRE_IW-1:0]    r_pre_idx;
`endif

  assign w_last    = (r_cnt == CNT_LAST);
  assign bit_ready = (r_state == S_IDLE) || ((r_state == S_SYM) && w_last);
  assign w_xfer    = bit_valid && bit_ready;
  assign w_active  = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef DDS_CTRL_PREAMBLE_EN
      S_IDLE: if (w_xfer) w_state_nxt = S_PRE;
      S_PRE:  if (w_last && (r_pre_idx == PRE_LAST)) w_state_nxt = S_SYM;
`else
      S_IDLE: if (w_xfer) w_state_nxt = S_SYM;
`endif
      S_SYM:  if (w_last && !w_xfer) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Symbol counter, latched mode, current symbol bit and first-symbol clear flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_mode <= '0;
      r_bit  <= 1'b0;
      r_clr  <= 1'b0;
    end else begin
      r_clr <= (r_state == S_IDLE) && w_xfer;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (w_xfer) begin
          r_mode <= mode;
`ifdef DDS_CTRL_PREAMBLE_EN
          r_bit  <= 1'b1;
`else
          r_bit  <= bit_in;
`endif
        end
      end else if (w_last) begin
        r_cnt <= '0;
        if (w_xfer) r_bit <= bit_in;
`ifdef DDS_CTRL_PREAMBLE_EN
        // Preamble alternates each symbol; the held data bit follows the last one.
        if (r_state == S_PRE) r_bit <= (r_pre_idx == PRE_LAST) ? r_held : ~r_bit;
`endif
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef DDS_CTRL_PREAMBLE_EN
  // Preamble symbol index and the data bit held back during the preamble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held    <= 1'b0;
      r_pre_idx <= '0;
    end else if ((r_state == S_IDLE) && w_xfer) begin
      r_held    <= bit_in;
      r_pre_idx <= '0;
    end else if ((r_state == S_PRE) && w_last) begin
      r_pre_idx <= r_pre_idx + 1'b1;
    end
  end
`endif

  // Output decode from registered state, counter, mode and symbol bit
  always_comb begin
    busy      = w_active;
    dds_en    = w_active;
    dds_clr   = r_clr;
    sym_start = w_active && (r_cnt == '0);
    phase_inc = '0;
    phase_off = '0;
    amp_en    = 1'b0;
    if (w_active) begin
      case (r_mode)
        2'b01: begin
          phase_inc = r_bit ? P_F1 : P_F0;
          amp_en    = 1'b1;
        end
        2'b10: begin
          phase_inc = P_F0;
          phase_off = r_bit ? P_HALF : '0;
          amp_en    = 1'b1;
        end
        default: begin
          phase_inc = P_F0;
          amp_en    = r_bit;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_mod_controller.sv
// tb_dds_mod_controller: directed bench for dds_mod_controller (default build,
// preamble disabled). A symbol-level model predicts every output each cycle;
// directed literal checks pin the model to hand-computed values.
module tb_dds_mod_controller;
  localparam int SYM = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready, dds_en, dds_clr, amp_en, sym_start, busy;
  logic [7:0] phase_inc, phase_off;

  int n_pass = 0;
  int n_total = 0;
  int n_symstart = 0;
  int n_clr = 0;
  bit cmp_en = 1'b0;

  dds_mod_controller #(
    .PHASE_WIDTH(8), .CNT_WIDTH(8), .SYMBOL_CYCLES(SYM),
    .INC_F0(1), .INC_F1(2), .PREAMBLE_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .dds_en(dds_en), .dds_clr(dds_clr),
    .phase_inc(phase_inc), .phase_off(phase_off), .amp_en(amp_en),
    .sym_start(sym_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Model: a burst is a sequence of symbols; each symbol is (bit, burst mode,
  // age in cycles since its first cycle, whether it opened the burst).
  bit       m_on = 1'b0;
  int       m_age = 0;
  bit       m_bit = 1'b0;
  bit       m_first = 1'b0;
  bit [1:0] m_mode = 2'b00;

  function automatic logic [21:0] expected();
    logic       rdy, en, clr, amp, st, bsy;
    logic [7:0] inc, off;
    rdy = !m_on || (m_age == SYM - 1);
    en = m_on; bsy = m_on;
    st  = m_on && (m_age == 0);
    clr = m_on && (m_age == 0) && m_first;
    inc = 8'd0; off = 8'd0; amp = 1'b0;
    if (m_on) begin
      if (m_mode == 2'b01) begin inc = m_bit ? 8'd2 : 8'd1; amp = 1'b1; end
      else if (m_mode == 2'b10) begin inc = 8'd1; off = m_bit ? 8'd128 : 8'd0; amp = 1'b1; end
      else begin inc = 8'd1; amp = m_bit; end
    end
    return {rdy, en, clr, inc, off, amp, st, bsy};
  endfunction

  // Model advance on each clock edge; reset empties the burst at once.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_on = 1'b0; m_age = 0; m_first = 1'b0;
    end else begin
      logic [21:0] e;
      bit xfer;
      e = expected();
      xfer = bit_valid && e[21];
      if (!m_on) begin
        if (xfer) begin m_on = 1'b1; m_age = 0; m_first = 1'b1; m_mode = mode; m_bit = bit_in; end
      end else if (m_age == SYM - 1) begin
        if (xfer) begin m_age = 0; m_first = 1'b0; m_bit = bit_in; end
        else m_on = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  // Every-cycle comparison against the model, plus pulse counters
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cycle", {10'd0, bit_ready, dds_en, dds_clr, phase_inc, phase_off, amp_en, sym_start, busy},
          {10'd0, expected()});
      if (sym_start) n_symstart++;
      if (dds_clr) n_clr++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bit_ready && n < 2 * SYM) begin cyc(); n++; end
    chk("ready_wait", 32'(bit_ready), 32'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pos;
    #3;
    chk("rst_ready", 32'(bit_ready), 32'd1);
    chk("rst_busy_en", {busy, dds_en, amp_en, dds_clr, sym_start}, 32'd0);
    repeat (2) cyc();
    rst = 1'b1;
    cmp_en = 1'b1;
    cyc();

    // FSK single bit 1
    mode = 2'b01; bit_in = 1'b1; bit_valid = 1'b1;
    cyc();
    bit_valid = 1'b0;
    chk("fsk_clr_start", {dds_clr, sym_start, dds_en, busy}, 32'hF);
    chk("fsk_inc", 32'(phase_inc), 32'd2);
    n = 0;
    while (!bit_ready && n < 200) begin cyc(); n++; end
    chk("fsk_ready_delay", n, 32'd63);
    cyc();
    chk("fsk_idle", {dds_en, busy, amp_en}, 32'd0);
    chk("fsk_idle_inc", 32'(phase_inc), 32'd0);

    // BPSK back-to-back 1,0,1 with valid held
    n_symstart = 0; n_clr = 0;
    mode = 2'b10; bit_in = 1'b1; bit_valid = 1'b1;
    cyc();
    chk("bpsk_off0", 32'(phase_off), 32'd128);
    bit_in = 1'b0;
    wait_ready(); cyc();
    chk("bpsk_off1", 32'(phase_off), 32'd0);
    chk("bpsk_noclr", 32'(dds_clr), 32'd0);
    bit_in = 1'b1;
    wait_ready(); cyc();
    chk("bpsk_off2", 32'(phase_off), 32'd128);
    bit_valid = 1'b0;
    wait_ready(); cyc();
    chk("bpsk_symstarts", n_symstart, 32'd3);
    chk("bpsk_clrs", n_clr, 32'd1);
    chk("bpsk_idle", 32'(busy), 32'd0);

    // ASK 0 then 1, mode changed mid-burst
    mode = 2'b00; bit_in = 1'b0; bit_valid = 1'b1;
    cyc();
    chk("ask_amp0", {amp_en, phase_inc}, 32'h001);
    mode = 2'b10; bit_in = 1'b1;
    wait_ready(); cyc();
    chk("ask_amp1", {amp_en, phase_inc}, 32'h101);
    chk("ask_mode_held", 32'(phase_off), 32'd0);
    bit_valid = 1'b0;
    wait_ready(); cyc();

    // Backpressure: valid held high, exactly one ready cycle per symbol
    mode = 2'b01; bit_in = 1'b0; bit_valid = 1'b1;
    cyc();
    bit_in = 1'b1;
    n = 0; pos = -1;
    for (int i = 0; i < SYM; i++) begin
      if (bit_ready) begin n++; pos = i; end
      cyc();
    end
    chk("bp_ready_count", n, 32'd1);
    chk("bp_ready_pos", pos, 32'd63);
    chk("bp_next_sym", {sym_start, phase_inc}, 32'h102);
    bit_valid = 1'b0;
    wait_ready(); cyc();

    // Reserved mode 11 behaves as ASK
    mode = 2'b11; bit_in = 1'b1; bit_valid = 1'b1;
    cyc();
    bit_valid = 1'b0;
    chk("m11_ask", {amp_en, phase_inc, phase_off}, 32'h10100);

    // Asynchronous reset mid-symbol
    repeat (10) cyc();
    rst = 1'b0;
    #1;
    chk("arst_ready", 32'(bit_ready), 32'd1);
    chk("arst_outs", {dds_en, dds_clr, phase_inc, phase_off, amp_en, sym_start, busy}, 32'd0);
    repeat (2) cyc();
    rst = 1'b1;
    repeat (3) cyc();
    chk("post_rst_idle", {busy, bit_ready}, 32'd1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
